// File: rtl/demux_1_4_feeder_v_pkg.sv
// Shared definitions for the 1-to-4 demux feeder: channel width, state encoding,
// request layout and the channel-to-select decode.
package demux_1_4_feeder_v_pkg;

    localparam int CHAN_W = 2;
    localparam int SEL_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              a;
    } req_t;

    function automatic logic [SEL_W-1:0] chan_to_sel(input logic [CHAN_W-1:0] chan);
        logic [SEL_W-1:0] sel;
        case (chan)
            2'd0:    sel = 4'b0001;
            2'd1:    sel = 4'b0010;
            2'd2:    sel = 4'b0100;
            2'd3:    sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/demux_1_4_feeder_v_if.sv
// Request handshake and demux-facing outputs of the feeder, bundled as one interface.
interface demux_1_4_feeder_v_if
    import demux_1_4_feeder_v_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                     i_valid;
    logic                     o_ready;
    logic [CHAN_W-1:0]        i_chan;
    logic                     i_a;
    logic [SEL_W-1:0]         o_sel_code;
    logic                     o_a;
    logic                     o_strobe;
    logic                     o_busy;
    logic [$clog2(DEPTH):0]   o_count;

    modport master (
        output i_valid, i_chan, i_a,
        input  o_ready, o_sel_code, o_a, o_strobe, o_busy, o_count
    );

    modport slave (
        input  i_valid, i_chan, i_a,
        output o_ready, o_sel_code, o_a, o_strobe, o_busy, o_count
    );
endinterface

// File: rtl/demux_1_4_feeder_v_fifo.sv
// Generic synchronous FIFO with wrapping pointers and an occupancy counter;
// the head entry is presented combinationally on rdata.
module sync_fifo_v #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests so overflow/underflow cannot corrupt state.
    always_comb begin
        push_ok_s = push && (count_r != CW'(DEPTH));
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
    end

    // Storage array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/demux_1_4_feeder_v.sv
// Paces queued (channel, bit) requests onto the demux select/data lines,
// holding each routing for HOLD cycles and strobing on every new routing.
module demux_1_4_feeder_v
    import demux_1_4_feeder_v_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    demux_1_4_feeder_v_if.slave   bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t             state_r;
    logic [HOLD_W-1:0]  hold_r;
    logic [SEL_W-1:0]   sel_r;
    logic               a_r;
    logic               strobe_r;
    logic               busy_r;

    logic [CNT_W-1:0]   count_s;
    req_t               head_s;
    req_t               wdata_s;
    logic               push_s;
    logic               pop_s;
    logic               ready_s;
    logic               nonempty_s;
    logic               hold_done_s;

    // Handshake and pop decisions; ready ignores the same-cycle pop on purpose.
    always_comb begin
        nonempty_s   = (count_s != {CNT_W{1'b0}});
        ready_s      = (count_s < CNT_W'(DEPTH));
        push_s       = bus.i_valid && ready_s;
        hold_done_s  = (hold_r == {HOLD_W{1'b0}});
        wdata_s.chan = bus.i_chan;
        wdata_s.a    = bus.i_a;
        if (state_r == ST_IDLE) begin
            pop_s = nonempty_s;
        end else begin
            pop_s = hold_done_s && nonempty_s;
        end
    end

    sync_fifo_v #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Sequencer FSM with hold counter and registered demux-facing outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            hold_r   <= {HOLD_W{1'b0}};
            sel_r    <= 4'b0000;
            a_r      <= 1'b0;
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r  <= ST_DRIVE;
                        hold_r   <= HOLD_W'(HOLD - 1);
                        sel_r    <= chan_to_sel(head_s.chan);
                        a_r      <= head_s.a;
                        strobe_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        hold_r   <= {HOLD_W{1'b0}};
                        sel_r    <= 4'b0000;
                        a_r      <= 1'b0;
                        strobe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (!hold_done_s) begin
                        hold_r   <= hold_r - HOLD_W'(1);
                        strobe_r <= 1'b0;
                    end else if (pop_s) begin
                        // Back-to-back: a repeated routing still gets a fresh period.
                        hold_r   <= HOLD_W'(HOLD - 1);
                        sel_r    <= chan_to_sel(head_s.chan);
                        a_r      <= head_s.a;
                        strobe_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        hold_r   <= {HOLD_W{1'b0}};
                        sel_r    <= 4'b0000;
                        a_r      <= 1'b0;
                        strobe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    hold_r   <= {HOLD_W{1'b0}};
                    sel_r    <= 4'b0000;
                    a_r      <= 1'b0;
                    strobe_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_s;
    assign bus.o_sel_code = sel_r;
    assign bus.o_a        = a_r;
    assign bus.o_strobe   = strobe_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_count    = count_s;

endmodule

// File: tb/tb_demux_1_4_feeder_v.sv
// Directed bench for demux_1_4_feeder_v: explicit cycle checks plus a negedge
// scoreboard that follows every routing against the accepted request order.
module tb_demux_1_4_feeder_v;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic clk;
    logic rst_n;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [2:0] exp_q [$];
    int         run_len       = 0;
    int         busy_len      = 0;
    int         last_busy_len = 0;
    int         strobes       = 0;
    bit         saw_full      = 1'b0;
    logic [3:0] cur_sel       = 4'b0000;
    logic       cur_a         = 1'b0;
    logic [2:0] mon_e;

    demux_1_4_feeder_v_if #(.DEPTH(DEPTH)) bus_if ();

    demux_1_4_feeder_v #(
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: each strobe must carry the next accepted request for HOLD cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len  = 0;
            busy_len = 0;
            exp_q.delete();
        end else begin
            if (bus_if.o_strobe) begin
                if (run_len > 0) check_val("hold_len", 32'(run_len), 32'(HOLD));
                check_val("strobe_busy", 32'(bus_if.o_busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check_val("spurious_strobe", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e   = exp_q.pop_front();
                    cur_sel = 4'b0001 << mon_e[2:1];
                    cur_a   = mon_e[0];
                    check_val("route_sel", 32'(bus_if.o_sel_code), 32'(cur_sel));
                    check_val("route_a", 32'(bus_if.o_a), 32'(cur_a));
                end
                run_len = 1;
                strobes++;
            end else if (bus_if.o_busy) begin
                run_len++;
                check_val("held_sel", 32'(bus_if.o_sel_code), 32'(cur_sel));
                check_val("held_a", 32'(bus_if.o_a), 32'(cur_a));
            end else begin
                if (run_len > 0) check_val("hold_len", 32'(run_len), 32'(HOLD));
                run_len = 0;
                check_val("idle_sel", 32'(bus_if.o_sel_code), 32'd0);
                check_val("idle_a", 32'(bus_if.o_a), 32'd0);
            end
            if (bus_if.o_busy) begin
                busy_len++;
            end else if (busy_len > 0) begin
                last_busy_len = busy_len;
                busy_len      = 0;
            end
            check_val("count", 32'(bus_if.o_count), 32'(exp_q.size()));
            check_val("ready", 32'(bus_if.o_ready), 32'(exp_q.size() < DEPTH));
            if (bus_if.o_count == 3'(DEPTH) && !bus_if.o_ready) saw_full = 1'b1;
        end
    end

    // Present one request (called at a negedge); returns at the negedge after acceptance.
    task automatic push_req(input logic [1:0] c, input logic d);
        bit acc;
        int k;
        acc = 1'b0;
        k   = 0;
        bus_if.i_valid = 1'b1;
        bus_if.i_chan  = c;
        bus_if.i_a     = d;
        while (!acc && k < 100) begin
            acc = bus_if.o_ready;
            @(posedge clk);
            if (acc) exp_q.push_back({c, d});
            @(negedge clk);
            k++;
        end
        if (!acc) check_val("push_timeout", 32'd0, 32'd1);
        bus_if.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 300 && (bus_if.o_busy || bus_if.o_count != 3'd0)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check_val("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        logic [2:0] v;
        rst_n          = 1'b0;
        bus_if.i_valid = 1'b0;
        bus_if.i_chan  = 2'd0;
        bus_if.i_a     = 1'b0;

        #3;
        check_val("rst_sel", 32'(bus_if.o_sel_code), 32'd0);
        check_val("rst_a", 32'(bus_if.o_a), 32'd0);
        check_val("rst_strobe", 32'(bus_if.o_strobe), 32'd0);
        check_val("rst_busy", 32'(bus_if.o_busy), 32'd0);
        check_val("rst_ready", 32'(bus_if.o_ready), 32'd1);
        check_val("rst_count", 32'(bus_if.o_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: chan 2, a 1.
        push_req(2'd2, 1'b1);
        check_val("single_count1", 32'(bus_if.o_count), 32'd1);
        check_val("single_notbusy", 32'(bus_if.o_busy), 32'd0);
        @(negedge clk);
        check_val("single_sel_c1", 32'(bus_if.o_sel_code), 32'h4);
        check_val("single_a_c1", 32'(bus_if.o_a), 32'd1);
        check_val("single_strobe_c1", 32'(bus_if.o_strobe), 32'd1);
        @(negedge clk);
        check_val("single_sel_c2", 32'(bus_if.o_sel_code), 32'h4);
        check_val("single_strobe_c2", 32'(bus_if.o_strobe), 32'd0);
        @(negedge clk);
        check_val("single_sel_c3", 32'(bus_if.o_sel_code), 32'h4);
        check_val("single_busy_c3", 32'(bus_if.o_busy), 32'd1);
        @(negedge clk);
        check_val("single_sel_end", 32'(bus_if.o_sel_code), 32'd0);
        check_val("single_busy_end", 32'(bus_if.o_busy), 32'd0);
        wait_idle();
        check_val("single_len", 32'(last_busy_len), 32'd3);

        // Back-to-back: four channels, no idle gap between routings.
        s0 = strobes;
        push_req(2'd0, 1'b1);
        push_req(2'd1, 1'b0);
        push_req(2'd2, 1'b1);
        push_req(2'd3, 1'b0);
        wait_idle();
        check_val("b2b_strobes", 32'(strobes - s0), 32'd4);
        check_val("b2b_len", 32'(last_busy_len), 32'd12);

        // Full FIFO: ready must drop and stalled requests must not be lost.
        saw_full = 1'b0;
        s0 = strobes;
        push_req(2'd1, 1'b1);
        push_req(2'd3, 1'b0);
        push_req(2'd0, 1'b1);
        push_req(2'd2, 1'b0);
        push_req(2'd1, 1'b0);
        push_req(2'd3, 1'b1);
        push_req(2'd0, 1'b0);
        wait_idle();
        check_val("full_seen", 32'(saw_full), 32'd1);
        check_val("full_strobes", 32'(strobes - s0), 32'd7);

        // Pointer wrap with irregular gaps between requests.
        s0 = strobes;
        for (int k = 0; k < 10; k++) begin
            v = 3'(k);
            push_req(v[1:0], v[2] ^ v[0]);
            repeat ((k % 2 == 0) ? 1 : 3) @(negedge clk);
        end
        wait_idle();
        check_val("wrap_strobes", 32'(strobes - s0), 32'd10);

        // All eight (chan, a) combinations.
        s0 = strobes;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            push_req(v[2:1], v[0]);
        end
        wait_idle();
        check_val("exh_strobes", 32'(strobes - s0), 32'd8);

        // Reset during DRIVE with entries still queued.
        push_req(2'd3, 1'b1);
        push_req(2'd1, 1'b1);
        push_req(2'd2, 1'b1);
        @(posedge clk);
        #2;
        check_val("pre_rst_busy", 32'(bus_if.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_sel", 32'(bus_if.o_sel_code), 32'd0);
        check_val("async_rst_a", 32'(bus_if.o_a), 32'd0);
        check_val("async_rst_busy", 32'(bus_if.o_busy), 32'd0);
        check_val("async_rst_count", 32'(bus_if.o_count), 32'd0);
        check_val("async_rst_ready", 32'(bus_if.o_ready), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_val("post_rst_busy", 32'(bus_if.o_busy), 32'd0);
        check_val("post_rst_count", 32'(bus_if.o_count), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
